rd_fwft_stage: RTL

RD_FWFT_STAGE -- requirements
Module: rd_fwft_stage

---
 rtl/rd_fwft_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rd_fwft_stage.sv
// -----------------------------------------------------------------------------
// rd_fwft_stage
//
// First-word-fall-through output stage for the read side of a FIFO. It issues
// pops to the read pointer handler, captures memory read data one cycle after
// each accepted pop, and holds up to two words in a small output buffer. The
// head word is presented on o_data with o_valid. The consumer takes it with
// i_ready.
//
// Optional feature: define RD_FWFT_LEVEL_EN to add the o_level output, which
// reports the current buffer occupancy (0, 1 or 2).
//
// Parameters
//   DATA_WIDTH  width of one FIFO word
//   DEPTH_BUF   number of output buffer entries (only 2 is supported)
//
// Ports
//   i_clk       read-domain clock
//   i_rstn      asynchronous active-low reset
//   i_empty     FIFO empty flag from the read pointer handler
//   o_rd_en     pop request to the read pointer handler
//   i_rd_data   memory read data, valid one cycle after an accepted pop
//   o_valid     o_data holds a valid word
//   i_ready     consumer accepts the head word this cycle
//   o_level     buffer occupancy (only with RD_FWFT_LEVEL_EN)
//   o_data      head-of-buffer word
// -----------------------------------------------------------------------------
module rd_fwft_stage #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH_BUF  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_empty,
    output logic                  o_rd_en,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_valid,
    input  logic                  i_ready,
`ifdef RD_FWFT_LEVEL_EN
    output logic [1:0]            o_level,
`endif
    output logic [DATA_WIDTH-1:0] o_data
);

    if (DEPTH_BUF != 2) begin : g_depth_check
        $error("rd_fwft_stage supports DEPTH_BUF == 2 only");
    end

    // The encoding of each state equals the buffer occupancy.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e                state_q;
    logic                  inflight_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;

    logic                  handshake;
    logic                  capture;
    logic [1:0]            cnt;
    logic [2:0]            committed;

    always_comb begin
        cnt       = state_q;
        // i_ready is only meaningful while a word is on offer.
        handshake = valid_q & i_ready;
        capture   = inflight_q;
        // Entries that will still be occupied or reserved after this edge.
        // cnt >= handshake always holds, so this never underflows.
        committed = {1'b0, cnt} + {2'b00, inflight_q} - {2'b00, handshake};
        // Gated by reset so no pop leaks out while the stage is held in reset.
        o_rd_en   = i_rstn & ~i_empty & (committed < 3'd2);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= StEmpty;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            // o_rd_en already includes !i_empty, so it is exactly an accepted pop.
            inflight_q <= o_rd_en;
            case (state_q)
                StEmpty: begin
                    if (capture) begin
                        head_q  <= i_rd_data;
                        valid_q <= 1'b1;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (handshake && capture) begin
                        // The head leaves and the new word replaces it directly.
                        head_q <= i_rd_data;
                    end else if (handshake) begin
                        valid_q <= 1'b0;
                        state_q <= StEmpty;
                    end else if (capture) begin
                        tail_q  <= i_rd_data;
                        state_q <= StTwo;
                    end
                end
                StTwo: begin
                    // A capture without a handshake cannot occur here because
                    // o_rd_en holds off pops while both entries are committed.
                    if (handshake) begin
                        head_q <= tail_q;
                        if (capture) begin
                            tail_q <= i_rd_data;
                        end else begin
                            state_q <= StOne;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= StEmpty;
                end
            endcase
        end
    end

    assign o_valid = valid_q;
    assign o_data  = head_q;

`ifdef RD_FWFT_LEVEL_EN
    assign o_level = cnt;
`endif

endmodule
